msrv32_machine_control: RTL and testbench
=========================================

MSRV32_MACHINE_CONTROL -- requirements
Module: msrv32_machine_control

Interface
REQ-001 SHALL have parameter WIDTH, default 32: datapath width, used only for documentation consistency with the PC path.
REQ-002 SHALL have port clk_in, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_in, input, 1, reset; asynchronous and active-low (0 = reset).
REQ-004 SHALL have port stall_in, input, 1, pipeline stall; when 1, state and registered outputs hold.
REQ-005 SHALL have ports illegal_instr_in, misaligned_instr_in, misaligned_load_in and misaligned_store_in, each input, 1, exception flags from decode and the PC path.
REQ-006 SHALL have ports opcode_6_to_2_in (input, 5), funct3_in (input, 3), funct7_in (input, 7), rs1_addr_in, rs2_addr_in and rd_addr_in (input, 5 each), the instruction fields.
REQ-007 SHALL have ports mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in and msip_in, each input, 1, the global enable, per-source enables and pending bits.
REQ-008 SHALL have port pc_src_out, output, 2, the PC-mux select: 00 boot, 01 epc, 10 trap, 11 next_pc.
REQ-009 SHALL have port flush_out, output, 1, which squashes the instruction in flight.
REQ-010 SHALL have ports trap_taken_out, set_epc_out, set_cause_out, mie_clear_out, mie_set_out, instret_inc_out and misaligned_exception_out, each output, 1, the CSR-unit controls.
REQ-011 SHALL have port cause_out, output, 4, the trap cause code.
REQ-012 SHALL have port i_or_e_out, output, 1: 1 = interrupt, 0 = exception.

Function
REQ-013 SHALL implement a 4-state FSM: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
REQ-014 SHALL decode SYSTEM as opcode_6_to_2_in=11100 with funct3=000: mret when funct7=0011000 and rs2=00010; ecall when funct7=0, rs2=0, rs1=0 and rd=0; ebreak when funct7=0, rs2=00001, rs1=0 and rd=0.
REQ-015 SHALL form exception as illegal | any misaligned | ecall | ebreak.
REQ-016 SHALL form interrupt as mie_in & ((meie&meip) | (mtie&mtip) | (msie&msip)).
REQ-017 SHALL use these transitions when stall_in=0: RESET->OPERATING unconditionally; OPERATING->TRAP_TAKEN on exception or interrupt; otherwise OPERATING->TRAP_RETURN on mret; otherwise remain in OPERATING; TRAP_TAKEN->OPERATING; TRAP_RETURN->OPERATING.
REQ-018 SHALL, when stall_in=1, hold the state and registered outputs, and force instret_inc_out=0.
REQ-019 SHALL drive pc_src_out as a Moore function of state: RESET 00, OPERATING 11, TRAP_TAKEN 10, TRAP_RETURN 01.
REQ-020 SHALL drive flush_out=1 in RESET, TRAP_TAKEN and TRAP_RETURN, and 0 in OPERATING.
REQ-021 SHALL drive trap_taken_out, set_epc_out, set_cause_out and mie_clear_out to 1 only in TRAP_TAKEN; mie_set_out to 1 only in TRAP_RETURN.
REQ-022 SHALL register cause_out and i_or_e_out on the OPERATING->TRAP_TAKEN edge and hold them until the next trap.
REQ-023 SHALL apply cause priority with exceptions first: misaligned_instr 0 > illegal 2 > ebreak 3 > ecall 11 > misaligned_load 4 > misaligned_store 6.
REQ-024 SHALL apply interrupt priority after exceptions: external 11 > software 3 > timer 7, with i_or_e_out=1.
REQ-025 SHALL handle simultaneous events as follows: exception plus interrupt takes the exception; mret plus pending interrupt takes the interrupt (mret is not executed, no TRAP_RETURN).
REQ-026 SHALL ignore interrupts and exceptions outside OPERATING.
REQ-027 SHALL assert instret_inc_out=1 in OPERATING with stall_in=0 and neither exception nor interrupt present; mret counts as retired.
REQ-028 SHALL assert misaligned_exception_out combinationally in OPERATING when any misaligned flag is 1, and 0 otherwise.

Reset
REQ-029 SHALL, on rst_in=0, immediately (asynchronously) set state=RESET, cause_out=0 and i_or_e_out=0.
REQ-030 SHALL, while in reset, present pc_src_out=00 and flush_out=1, with all other outputs 0.
REQ-031 SHALL abandon any in-progress trap or return when reset is asserted mid-operation, without completing its CSR pulses.
REQ-032 SHALL, after rst_in rises, spend exactly one cycle in RESET before entering OPERATING.

Verification
REQ-033 SHALL cover release from reset: pc_src 00 and flush 1 for 1 cycle, then pc_src 11 and instret_inc 1.
REQ-034 SHALL cover ecall (opcode 11100, all other fields 0): next cycle pc_src 10, cause 11, i_or_e 0, set_epc, set_cause and mie_clear pulse for 1 cycle, then pc_src 11.
REQ-035 SHALL cover mret with no interrupt: 1 cycle of pc_src 01, mie_set 1 and flush 1.
REQ-036 SHALL cover illegal_instr plus meip/meie/mie all 1: cause 2, i_or_e 0; after return with mie_in 1, the next trap is cause 11, i_or_e 1.
REQ-037 SHALL cover msip and mtip both enabled: cause 3; and stall_in=1 held for 3 cycles during TRAP_TAKEN keeps pc_src 10 for all 3 cycles.
REQ-038 SHALL cover rst_in dropped during TRAP_TAKEN: pc_src 00 and set_epc 0 within the same cycle.

Source files
------------

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap controller: steers the PC mux, squashes the instruction in
// flight and pulses the CSR unit on trap entry (exception/interrupt) and mret.
module msrv32_machine_control #(
    parameter int WIDTH = 32
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       stall_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       misaligned_exception_out,
    output logic [3:0] cause_out,
    output logic       i_or_e_out,
    output logic [1:0] state_out
);

    // WIDTH only mirrors the PC datapath width; nothing here depends on it.
    if (WIDTH < 32) begin : g_narrow_pc_unsupported
    end

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    state_t     state;
    state_t     next_state;
    logic       trap_pulse;
    logic       is_system;
    logic       is_mret;
    logic       is_ecall;
    logic       is_ebreak;
    logic       any_misaligned;
    logic       exception;
    logic       interrupt;
    logic       take_trap;
    logic [3:0] trap_cause;

    assign is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
    assign is_mret   = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);
    assign is_ecall  = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd0)
                       && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign is_ebreak = is_system && (funct7_in == 7'd0) && (rs2_addr_in == 5'd1)
                       && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);

    assign any_misaligned = misaligned_instr_in | misaligned_load_in | misaligned_store_in;
    assign exception = illegal_instr_in | any_misaligned | is_ecall | is_ebreak;
    assign interrupt = mie_in & ((meie_in & meip_in) | (mtie_in & mtip_in) | (msie_in & msip_in));
    assign take_trap = (state == ST_OPERATING) && (exception || interrupt);

    // Exceptions outrank interrupts; among interrupts external > software > timer.
    always_comb begin
        trap_cause = 4'd0;
        if (misaligned_instr_in)               trap_cause = 4'd0;
        else if (illegal_instr_in)             trap_cause = 4'd2;
        else if (is_ebreak)                    trap_cause = 4'd3;
        else if (is_ecall)                     trap_cause = 4'd11;
        else if (misaligned_load_in)           trap_cause = 4'd4;
        else if (misaligned_store_in)          trap_cause = 4'd6;
        else if (meie_in & meip_in)            trap_cause = 4'd11;
        else if (msie_in & msip_in)            trap_cause = 4'd3;
        else if (mtie_in & mtip_in)            trap_cause = 4'd7;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_RESET:       next_state = ST_OPERATING;
            ST_OPERATING: begin
                if (exception || interrupt) next_state = ST_TRAP_TAKEN;
                else if (is_mret)           next_state = ST_TRAP_RETURN;
                else                        next_state = ST_OPERATING;
            end
            ST_TRAP_TAKEN:  next_state = ST_OPERATING;
            ST_TRAP_RETURN: next_state = ST_OPERATING;
            default:        next_state = ST_RESET;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_RESET;
            pc_src_out  <= PC_BOOT;
            flush_out   <= 1'b1;
            trap_pulse  <= 1'b0;
            mie_set_out <= 1'b0;
            cause_out   <= 4'd0;
            i_or_e_out  <= 1'b0;
        end else if (!stall_in) begin
            state       <= next_state;
            flush_out   <= (next_state != ST_OPERATING);
            trap_pulse  <= (next_state == ST_TRAP_TAKEN);
            mie_set_out <= (next_state == ST_TRAP_RETURN);
            case (next_state)
                ST_RESET:       pc_src_out <= PC_BOOT;
                ST_OPERATING:   pc_src_out <= PC_NEXT;
                ST_TRAP_TAKEN:  pc_src_out <= PC_TRAP;
                ST_TRAP_RETURN: pc_src_out <= PC_EPC;
                default:        pc_src_out <= PC_BOOT;
            endcase
            if (take_trap) begin
                cause_out  <= trap_cause;
                i_or_e_out <= ~exception;
            end
        end
    end

    assign trap_taken_out = trap_pulse;
    assign set_epc_out    = trap_pulse;
    assign set_cause_out  = trap_pulse;
    assign mie_clear_out  = trap_pulse;

    assign instret_inc_out = (state == ST_OPERATING) && !stall_in && !exception && !interrupt;
    assign misaligned_exception_out = (state == ST_OPERATING) && any_misaligned;
    assign state_out = state;

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed bench for msrv32_machine_control: a vector table of single-instruction
// trap scenarios plus hand-written reset, stall and back-to-back trap sequences.
module tb_msrv32_machine_control;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       stall_in;
    logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic [1:0] pc_src_out;
    logic       flush_out, trap_taken_out, set_epc_out, set_cause_out, mie_clear_out;
    logic       mie_set_out, instret_inc_out, misaligned_exception_out;
    logic [3:0] cause_out;
    logic       i_or_e_out;
    logic [1:0] state_out;

    int total = 0;
    int bad   = 0;

    msrv32_machine_control #(.WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in),
        .illegal_instr_in(illegal_instr_in), .misaligned_instr_in(misaligned_instr_in),
        .misaligned_load_in(misaligned_load_in), .misaligned_store_in(misaligned_store_in),
        .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
        .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
        .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
        .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
        .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out),
        .set_epc_out(set_epc_out), .set_cause_out(set_cause_out), .mie_clear_out(mie_clear_out),
        .mie_set_out(mie_set_out), .instret_inc_out(instret_inc_out),
        .misaligned_exception_out(misaligned_exception_out), .cause_out(cause_out),
        .i_or_e_out(i_or_e_out), .state_out(state_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rs1, rs2, rd;
        logic [3:0] exc;      // {illegal, mis_instr, mis_load, mis_store}
        logic [6:0] irq;      // {mie, meie, mtie, msie, meip, mtip, msip}
        logic       exp_instret;
        logic       exp_mis;
        logic [1:0] exp_pc;   // pc_src one cycle later
        logic [3:0] exp_cause;
        logic       exp_ioe;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(logic [4:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic [3:0] exc, logic [6:0] irq, logic ins, logic mis,
                                logic [1:0] pc, logic [3:0] cause, logic ioe);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.exc = exc; v.irq = irq; v.exp_instret = ins; v.exp_mis = mis;
        v.exp_pc = pc; v.exp_cause = cause; v.exp_ioe = ioe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic clear_inputs();
        {illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in} = 4'b0;
        {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = 7'b0;
        opcode_6_to_2_in = 5'b01100;
        funct3_in = 3'd0; funct7_in = 7'd0;
        rs1_addr_in = 5'd0; rs2_addr_in = 5'd0; rd_addr_in = 5'd0;
    endtask

    task automatic drive_vec(input vec_t v);
        opcode_6_to_2_in = v.op; funct3_in = v.f3; funct7_in = v.f7;
        rs1_addr_in = v.rs1; rs2_addr_in = v.rs2; rd_addr_in = v.rd;
        {illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in} = v.exc;
        {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = v.irq;
    endtask

    // Checks every Moore output against the pc_src value expected for the current state.
    task automatic chk_moore(input string tag, input logic [1:0] pc);
        chk({tag, " pc_src"}, 32'(pc_src_out), 32'(pc));
        chk({tag, " flush"}, 32'(flush_out), 32'(pc != 2'b11));
        chk({tag, " trap_taken"}, 32'(trap_taken_out), 32'(pc == 2'b10));
        chk({tag, " set_epc"}, 32'(set_epc_out), 32'(pc == 2'b10));
        chk({tag, " set_cause"}, 32'(set_cause_out), 32'(pc == 2'b10));
        chk({tag, " mie_clear"}, 32'(mie_clear_out), 32'(pc == 2'b10));
        chk({tag, " mie_set"}, 32'(mie_set_out), 32'(pc == 2'b01));
    endtask

    initial begin
        vecs[0]  = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0000000, 1, 0, 2'b11, 4'd0,  0);
        vecs[1]  = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0000000, 0, 0, 2'b10, 4'd11, 0);
        vecs[2]  = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 4'b0000, 7'b0000000, 0, 0, 2'b10, 4'd3,  0);
        vecs[3]  = mk(5'b11100, 3'd0, 7'h18, 5'd0, 5'd2, 5'd0, 4'b0000, 7'b0000000, 1, 0, 2'b01, 4'd3,  0);
        vecs[4]  = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b1000, 7'b0000000, 0, 0, 2'b10, 4'd2,  0);
        vecs[5]  = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b1100, 7'b0000000, 0, 1, 2'b10, 4'd0,  0);
        vecs[6]  = mk(5'b00000, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3, 4'b0010, 7'b0000000, 0, 1, 2'b10, 4'd4,  0);
        vecs[7]  = mk(5'b01000, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 4'b0001, 7'b0000000, 0, 1, 2'b10, 4'd6,  0);
        vecs[8]  = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0011, 7'b0000000, 0, 1, 2'b10, 4'd4,  0);
        vecs[9]  = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0000000, 0, 1, 2'b10, 4'd11, 0);
        vecs[10] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1010010, 0, 0, 2'b10, 4'd7,  1);
        vecs[11] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1011011, 0, 0, 2'b10, 4'd3,  1);
        vecs[12] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1101101, 0, 0, 2'b10, 4'd11, 1);
        vecs[13] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0100100, 1, 0, 2'b11, 4'd11, 1);
        vecs[14] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b1000100, 1, 0, 2'b11, 4'd11, 1);
        vecs[15] = mk(5'b11100, 3'd0, 7'h18, 5'd0, 5'd2, 5'd0, 4'b0000, 7'b1010010, 0, 0, 2'b10, 4'd7,  1);
        vecs[16] = mk(5'b11100, 3'd1, 7'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 7'b0000000, 1, 0, 2'b11, 4'd7,  1);
        vecs[17] = mk(5'b01100, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 4'b1000, 7'b1100100, 0, 0, 2'b10, 4'd2,  0);
        vecs[18] = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd1, 5'd1, 4'b0000, 7'b0000000, 1, 0, 2'b11, 4'd2,  0);
        vecs[19] = mk(5'b11100, 3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 4'b0001, 7'b0000000, 0, 1, 2'b10, 4'd3,  0);
        vecs[20] = mk(5'b11100, 3'd0, 7'h18, 5'd0, 5'd2, 5'd0, 4'b1000, 7'b0000000, 0, 0, 2'b10, 4'd2,  0);

        // Reset and release
        rst_in = 1'b0;
        stall_in = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk_in);
        chk_moore("reset", 2'b00);
        chk("reset cause", 32'(cause_out), 32'd0);
        chk("reset i_or_e", 32'(i_or_e_out), 32'd0);
        chk("reset instret", 32'(instret_inc_out), 32'd0);
        chk("reset misaligned", 32'(misaligned_exception_out), 32'd0);
        chk("reset state", 32'(state_out), 32'd0);
        rst_in = 1'b1;
        #1;
        chk_moore("release cycle", 2'b00);
        tick();
        chk_moore("after release", 2'b11);
        chk("after release instret", 32'(instret_inc_out), 32'd1);

        // Table-driven single-instruction scenarios, each started in OPERATING
        for (int i = 0; i < NV; i++) begin
            drive_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d instret", i), 32'(instret_inc_out), 32'(vecs[i].exp_instret));
            chk($sformatf("vec%0d misaligned", i), 32'(misaligned_exception_out), 32'(vecs[i].exp_mis));
            tick();
            chk_moore($sformatf("vec%0d", i), vecs[i].exp_pc);
            chk($sformatf("vec%0d cause", i), 32'(cause_out), 32'(vecs[i].exp_cause));
            chk($sformatf("vec%0d i_or_e", i), 32'(i_or_e_out), 32'(vecs[i].exp_ioe));
            clear_inputs();
            #1;
            chk($sformatf("vec%0d misaligned outside operating", i),
                32'(misaligned_exception_out), 32'd0);
            if (vecs[i].exp_pc != 2'b11)
                chk($sformatf("vec%0d instret outside operating", i), 32'(instret_inc_out), 32'd0);
            tick();
            chk_moore($sformatf("vec%0d back", i), 2'b11);
        end

        // Stall in OPERATING holds state and suppresses instret
        stall_in = 1'b1;
        opcode_6_to_2_in = 5'b11100;
        #1;
        chk("stall op instret", 32'(instret_inc_out), 32'd0);
        tick();
        chk_moore("stall op hold", 2'b11);
        chk("stall op cause held", 32'(cause_out), 32'd2);
        stall_in = 1'b0;
        tick();
        chk_moore("ecall after stall", 2'b10);
        chk("ecall after stall cause", 32'(cause_out), 32'd11);
        clear_inputs();
        tick();
        chk_moore("ecall after stall back", 2'b11);

        // Software + timer pending, then stall for 3 cycles in TRAP_TAKEN
        {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = 7'b1011011;
        tick();
        chk_moore("sw+timer trap", 2'b10);
        chk("sw+timer cause", 32'(cause_out), 32'd3);
        chk("sw+timer i_or_e", 32'(i_or_e_out), 32'd1);
        clear_inputs();
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_moore($sformatf("trap stall %0d", k), 2'b10);
            chk($sformatf("trap stall %0d instret", k), 32'(instret_inc_out), 32'd0);
        end
        stall_in = 1'b0;
        tick();
        chk_moore("trap stall released", 2'b11);

        // Illegal beats a pending external interrupt, which is taken after return
        illegal_instr_in = 1'b1;
        {mie_in, meie_in, meip_in} = 3'b111;
        tick();
        chk("illegal+ext cause", 32'(cause_out), 32'd2);
        chk("illegal+ext i_or_e", 32'(i_or_e_out), 32'd0);
        illegal_instr_in = 1'b0;
        tick();
        chk_moore("ignored in trap", 2'b11);
        tick();
        chk_moore("ext after return", 2'b10);
        chk("ext after return cause", 32'(cause_out), 32'd11);
        chk("ext after return i_or_e", 32'(i_or_e_out), 32'd1);
        clear_inputs();
        tick();

        // Reset dropped during TRAP_TAKEN
        opcode_6_to_2_in = 5'b11100;
        tick();
        chk("pre-reset set_epc", 32'(set_epc_out), 32'd1);
        chk("pre-reset cause", 32'(cause_out), 32'd11);
        clear_inputs();
        rst_in = 1'b0;
        #1;
        chk_moore("mid-trap reset", 2'b00);
        chk("mid-trap reset cause", 32'(cause_out), 32'd0);
        chk("mid-trap reset i_or_e", 32'(i_or_e_out), 32'd0);
        tick();
        rst_in = 1'b1;
        #1;
        chk_moore("mid-trap release", 2'b00);
        tick();
        chk_moore("mid-trap operating", 2'b11);
        chk("mid-trap operating instret", 32'(instret_inc_out), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
